// File: rtl/deser_queue_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver with word queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deser_queue_pkg;

    // Word assembly: COLLECT accepts serial bits, HOLD parks a finished word
    // that found the queue full and refuses further bits until it is pushed.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } asm_state_t;

    // Bit position within the word for the count-th received bit.
    // LSB-first puts the first bit in word[0]; MSB-first in word[data_w-1].
    function automatic int bit_slot(input int count, input int data_w, input bit msb_first);
        return msb_first ? (data_w - 1 - count) : count;
    endfunction

endpackage

// File: rtl/sync_fwft_queue.sv
// First-word-fall-through queue, DEPTH entries of DATA_W bits, head registered.
// Latency: a pushed word is visible on head/len the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge; pop on empty is ignored.
//
// Ports: clock/reset (async active-low), push/push_data (write side),
//        pop (read side), head (current head word), len (0..DEPTH), full.
module sync_fwft_queue #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 8,
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LEN_W-1:0]  len,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] head_q;
    logic              do_pop;
    logic              do_push;

    assign full       = (len_q == LEN_W'(DEPTH));
    assign do_pop     = pop && (len_q != '0);
    // A pop on the same edge frees the slot, so a push into a full queue still lands.
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

    assign head = head_q;
    assign len  = len_q;

    // Storage array carries no reset: contents are only ever read behind len_q.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            len_q  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (do_push && !do_pop) begin
                len_q <= len_q + LEN_W'(1);
            end else if (!do_push && do_pop) begin
                len_q <= len_q - LEN_W'(1);
            end
            // Head register: the incoming word becomes head when the queue is
            // (or is about to become) empty; otherwise a pop pulls the next entry.
            // Popping the last entry without a push leaves the old value in place.
            if (do_push && ((len_q == '0) || (do_pop && (len_q == LEN_W'(1))))) begin
                head_q <= push_data;
            end else if (do_pop && (len_q != LEN_W'(1))) begin
                head_q <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/deser_queue_param.sv
// Serial-to-parallel receiver: assembles DATA_W bits into words and queues them (FWFT, DEPTH entries).
// Latency: a word appears on data_out/len_out the cycle after the edge that samples its last bit.
// Backpressure: a finished word that meets a full queue is parked (status_out=0); bits arriving then are dropped with a drop_out pulse.
//
// Ports: clock/reset (async active-low); data_in + write_in serial input;
//        status_out (1 = accepting bits); dequeue_in pop request;
//        data_out head word; len_out occupancy; full_out; drop_out 1-cycle pulse.
module deser_queue_param #(
    parameter int  DATA_W    = 8,
    parameter int  DEPTH     = 8,
    parameter int  MSB_FIRST = 0,
    parameter int  EDGE_MODE = 1,
    localparam int LEN_W     = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    output logic              status_out,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
    output logic              drop_out
);

    import deser_queue_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    // Strobe qualification
    logic wr_q;
    logic dq_q;
    logic wr_stb;
    logic dq_stb;

    // Assembly state
    asm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              status_q;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  slot;
    logic [DATA_W-1:0] word_nxt;

    // Queue interface
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              space;
    logic [LEN_W-1:0]  q_len;
    logic              q_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= 1'b0;
            dq_q <= 1'b0;
        end else begin
            wr_q <= write_in;
            dq_q <= dequeue_in;
        end
    end

    // Edge mode: act only on the cycle the strobe is first seen high.
    assign wr_stb = (EDGE_MODE != 0) ? (write_in && !wr_q)   : write_in;
    assign dq_stb = (EDGE_MODE != 0) ? (dequeue_in && !dq_q) : dequeue_in;

    assign pop   = dq_stb && (q_len != '0);
    assign space = !q_full || pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            asm_q    <= '0;
            pend_q   <= '0;
            status_q <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            pend_q   <= pend_d;
            status_q <= (state_d == COLLECT);
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        pend_d    = pend_q;
        drop_d    = 1'b0;
        push      = 1'b0;
        push_data = asm_q;
        slot      = CNT_W'(bit_slot(int'(cnt_q), DATA_W, MSB_FIRST != 0));
        word_nxt  = asm_q;
        word_nxt[slot] = data_in;

        case (state_q)
            COLLECT: begin
                if (wr_stb) begin
                    asm_d = word_nxt;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d = '0;
                        if (space) begin
                            push      = 1'b1;
                            push_data = word_nxt;
                        end else begin
                            pend_d  = word_nxt;
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Bits are refused for the whole cycle status_out reads 0,
                // including the edge on which the parked word finally drains.
                drop_d = wr_stb;
                if (space) begin
                    push      = 1'b1;
                    push_data = pend_q;
                    state_d   = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    sync_fwft_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (data_out),
        .len       (q_len),
        .full      (q_full)
    );

    assign len_out    = q_len;
    assign full_out   = q_full;
    assign status_out = status_q;
    assign drop_out   = drop_q;

endmodule

// File: tb/tb_deser_queue_param.sv
module tb_deser_queue_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: defaults (8-bit, depth 8, LSB-first, edge mode)
    logic       a_data, a_wr, a_dq;
    logic       a_status, a_full, a_drop;
    logic [7:0] a_dout;
    logic [3:0] a_len;

    // Instance B: MSB-first
    logic       b_data, b_wr, b_dq;
    logic       b_status, b_full, b_drop;
    logic [7:0] b_dout;
    logic [3:0] b_len;

    // Instance C: 12-bit words, depth 4, level mode
    logic        c_data, c_wr, c_dq;
    logic        c_status, c_full, c_drop;
    logic [11:0] c_dout;
    logic [2:0]  c_len;

    int total = 0;
    int bad   = 0;
    logic [11:0] sb[$];

    deser_queue_param #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(0), .EDGE_MODE(1)) u_a (
        .clock(clk), .reset(rst_n), .data_in(a_data), .write_in(a_wr),
        .status_out(a_status), .dequeue_in(a_dq), .data_out(a_dout),
        .len_out(a_len), .full_out(a_full), .drop_out(a_drop));

    deser_queue_param #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(1), .EDGE_MODE(1)) u_b (
        .clock(clk), .reset(rst_n), .data_in(b_data), .write_in(b_wr),
        .status_out(b_status), .dequeue_in(b_dq), .data_out(b_dout),
        .len_out(b_len), .full_out(b_full), .drop_out(b_drop));

    deser_queue_param #(.DATA_W(12), .DEPTH(4), .MSB_FIRST(0), .EDGE_MODE(0)) u_c (
        .clock(clk), .reset(rst_n), .data_in(c_data), .write_in(c_wr),
        .status_out(c_status), .dequeue_in(c_dq), .data_out(c_dout),
        .len_out(c_len), .full_out(c_full), .drop_out(c_drop));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One edge-mode bit on A, strobe held high for 'hold' cycles.
    task automatic a_bit(input logic b, input int hold);
        @(negedge clk);
        a_data = b;
        a_wr   = 1'b1;
        repeat (hold) @(negedge clk);
        a_wr = 1'b0;
    endtask

    task automatic a_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) a_bit(w[i], 1);
    endtask

    task automatic a_pop();
        @(negedge clk);
        a_dq = 1'b1;
        @(negedge clk);
        a_dq = 1'b0;
    endtask

    task automatic b_bit(input logic b, input int hold);
        @(negedge clk);
        b_data = b;
        b_wr   = 1'b1;
        repeat (hold) @(negedge clk);
        b_wr = 1'b0;
    endtask

    initial begin
        logic [7:0]  w8;
        logic [11:0] w12;

        a_data = 0; a_wr = 0; a_dq = 0;
        b_data = 0; b_wr = 0; b_dq = 0;
        c_data = 0; c_wr = 0; c_dq = 0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset state
        chk("rst_status", a_status, 1);
        chk("rst_len",    a_len,    0);
        chk("rst_full",   a_full,   0);
        chk("rst_drop",   a_drop,   0);
        chk("rst_dout",   a_dout,   0);
        chk("rst_c_status", c_status, 1);
        chk("rst_c_len",    c_len,    0);

        // 2: 8'hA5 LSB-first, strobe held 10 cycles per bit
        w8 = 8'hA5;
        for (int i = 0; i < 7; i++) a_bit(w8[i], 10);
        chk("a5_len_before_last", a_len, 0);
        @(negedge clk);
        a_data = w8[7];
        a_wr   = 1'b1;
        @(posedge clk);
        #1;
        chk("a5_len_after_last",  a_len,  1);
        chk("a5_dout_after_last", a_dout, 8'hA5);
        repeat (9) @(negedge clk);
        a_wr = 1'b0;
        @(negedge clk);
        chk("a5_len_held", a_len, 1);

        // 3: MSB-first instance, 8'h0F sent LSB-first lands as 8'hF0
        w8 = 8'h0F;
        for (int i = 0; i < 8; i++) b_bit(w8[i], 10);
        @(negedge clk);
        chk("msb_dout", b_dout, 8'hF0);
        chk("msb_len",  b_len,  1);
        chk("msb_drop", b_drop, 0);

        // 4: fill, overflow into HOLD, drop, then pop releases pending word
        a_pop();
        chk("pop_a5_len", a_len, 0);
        for (int k = 1; k <= 8; k++) a_word(8'(k));
        @(negedge clk);
        chk("fill_len",    a_len,    8);
        chk("fill_full",   a_full,   1);
        chk("fill_status", a_status, 1);
        chk("fill_dout",   a_dout,   8'h01);
        a_word(8'h09);
        @(negedge clk);
        chk("hold_status", a_status, 0);
        chk("hold_full",   a_full,   1);
        chk("hold_len",    a_len,    8);
        @(negedge clk);
        a_data = 1'b1;
        a_wr   = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_drop_pulse", a_drop, 1);
        @(negedge clk);
        a_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_drop_end", a_drop, 0);
        @(negedge clk);
        a_dq = 1'b1;
        @(posedge clk);
        #1;
        chk("release_len",    a_len,    8);
        chk("release_status", a_status, 1);
        chk("release_dout",   a_dout,   8'h02);
        chk("release_full",   a_full,   1);
        @(negedge clk);
        a_dq = 1'b0;

        // 5: last bit and pop on the same edge while full
        w8 = 8'h0A;
        for (int i = 0; i < 7; i++) a_bit(w8[i], 1);
        @(negedge clk);
        a_data = w8[7];
        a_wr   = 1'b1;
        a_dq   = 1'b1;
        @(posedge clk);
        #1;
        chk("same_edge_len",    a_len,    8);
        chk("same_edge_drop",   a_drop,   0);
        chk("same_edge_status", a_status, 1);
        chk("same_edge_dout",   a_dout,   8'h03);
        @(negedge clk);
        a_wr = 1'b0;
        a_dq = 1'b0;
        @(negedge clk);
        chk("same_edge_status2", a_status, 1);
        for (int k = 0; k < 8; k++) begin
            chk("drain_order", a_dout, 32'(k + 3));
            a_pop();
        end
        chk("drain_len", a_len, 0);

        // 6: pop on empty, reset mid-word, fresh word
        a_pop();
        chk("empty_pop_len", a_len, 0);
        for (int i = 0; i < 4; i++) a_bit(1'b1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_len",    a_len,    0);
        chk("midrst_status", a_status, 1);
        a_word(8'h3C);
        @(negedge clk);
        chk("fresh_dout", a_dout, 8'h3C);
        chk("fresh_len",  a_len,  1);

        // Level-mode sweep on 12-bit / depth-4 instance with scoreboard
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            c_wr = 1'b1;
            for (int wd = 0; wd < 5; wd++) begin
                w12 = 12'($urandom_range(0, 4095));
                sb.push_back(w12);
                for (int i = 0; i < 12; i++) begin
                    c_data = w12[i];
                    @(negedge clk);
                end
            end
            c_wr = 1'b0;
            chk("sweep_full",   c_full,   1);
            chk("sweep_status", c_status, 0);
            chk("sweep_len",    c_len,    4);
            c_wr = 1'b1;
            @(posedge clk);
            #1;
            chk("sweep_drop", c_drop, 1);
            @(negedge clk);
            c_wr = 1'b0;
            c_dq = 1'b1;
            for (int k = 0; k < 5; k++) begin
                chk("sweep_pop", c_dout, sb.pop_front());
                @(negedge clk);
                if (k == 0) chk("sweep_status_back", c_status, 1);
            end
            c_dq = 1'b0;
            chk("sweep_drain_len", c_len, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
